// File: rtl/aes_cbc_pkg.sv
// Shared types and constants for the AES-CBC engine.
package aes_cbc_pkg;

    localparam int unsigned BLK_W = 128;
    localparam int unsigned KEY_W = 256;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;
    localparam logic ENC        = 1'b1;
    localparam logic DEC        = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYINIT,
        S_KEYWAIT,
        S_WAIT_IN,
        S_CORE_GO,
        S_CORE_WAIT,
        S_OUT,
        S_FIN
    } cbc_state_t;

endpackage

// File: rtl/aes_cbc_chain.sv
// CBC chaining register with the pre-core and post-core XOR paths.
module aes_cbc_chain
    import aes_cbc_pkg::*;
#(
    parameter logic [BLK_W-1:0] IV_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_update,
    input  logic             i_encrypt,
    input  logic             i_bypass,
    input  logic [BLK_W-1:0] i_iv,
    input  logic [BLK_W-1:0] i_in_data,
    input  logic [BLK_W-1:0] i_blk_in,
    input  logic [BLK_W-1:0] i_result,
    output logic [BLK_W-1:0] o_core_block,
    output logic [BLK_W-1:0] o_out_data
);

    logic [BLK_W-1:0] r_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= IV_RESET;
        end else if (i_load) begin
            r_chain <= i_iv;
        end else if (i_update && !i_bypass) begin
            r_chain <= i_encrypt ? i_result : i_blk_in;
        end
    end

    assign o_core_block = (i_encrypt && !i_bypass) ? (r_chain ^ i_in_data) : i_in_data;
    assign o_out_data   = (!i_encrypt && !i_bypass) ? (i_result ^ r_chain) : i_result;

endmodule

// File: rtl/aes_core.sv
// Iterative AES-128/256 block core (init/next/ready/result_valid interface),
// one round per cycle, key schedule expanded one word per cycle on init.
module aes_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         encdec,
    input  logic         init,
    input  logic         next,
    output logic         ready,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [127:0] result,
    output logic         result_valid
);

    typedef enum logic [1:0] {C_IDLE, C_KEYEXP, C_RUN} core_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte k of the state is row k%4, column k/4.
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a [4];
        for (int unsigned k = 0; k < 16; k++)
            t[127-8*k -: 8] = sbox(s[127-8*(4*(((k/4) + (k%4)) % 4) + (k%4)) -: 8]);
        if (last) return t ^ rk;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) a[r] = t[127-8*(4*c+r) -: 8];
            m[127-32*c -: 32] = {xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3],
                                 a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3],
                                 a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3],
                                 xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3])};
        end
        return m ^ rk;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a [4];
        for (int unsigned k = 0; k < 16; k++)
            t[127-8*k -: 8] = inv_sbox(s[127-8*(4*(((k/4) + 4 - (k%4)) % 4) + (k%4)) -: 8]);
        t = t ^ rk;
        if (last) return t;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) a[r] = t[127-8*(4*c+r) -: 8];
            m[127-32*c -: 32] = {
                gmul(a[0], 8'd14) ^ gmul(a[1], 8'd11) ^ gmul(a[2], 8'd13) ^ gmul(a[3], 8'd9),
                gmul(a[0], 8'd9)  ^ gmul(a[1], 8'd14) ^ gmul(a[2], 8'd11) ^ gmul(a[3], 8'd13),
                gmul(a[0], 8'd13) ^ gmul(a[1], 8'd9)  ^ gmul(a[2], 8'd14) ^ gmul(a[3], 8'd11),
                gmul(a[0], 8'd11) ^ gmul(a[1], 8'd13) ^ gmul(a[2], 8'd9)  ^ gmul(a[3], 8'd14)};
        end
        return m;
    endfunction

    core_state_t  r_state;
    logic         r_ready;
    logic         r_valid;
    logic [127:0] r_result;
    logic [127:0] r_blk;
    logic [3:0]   r_round;
    logic [3:0]   r_nr;
    logic         r_enc;
    logic         r_k256;
    logic [5:0]   r_widx;
    logic [7:0]   r_rcon;
    logic [31:0]  r_w [0:59];

    logic [3:0]   w_rk_idx;
    logic [127:0] w_rk;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_temp;
    logic         w_phase0;
    logic         w_phase4;
    logic [5:0]   w_last_word;

    always_comb begin
        if (r_state == C_RUN) w_rk_idx = r_enc ? r_round : r_nr - r_round;
        else                  w_rk_idx = encdec ? 4'd0 : r_nr;
        w_rk = {r_w[{w_rk_idx, 2'd0}], r_w[{w_rk_idx, 2'd1}],
                r_w[{w_rk_idx, 2'd2}], r_w[{w_rk_idx, 2'd3}]};
        w_prev      = r_w[r_widx - 6'd1];
        w_back      = r_w[r_widx - (r_k256 ? 6'd8 : 6'd4)];
        w_phase0    = r_k256 ? (r_widx[2:0] == 3'd0) : (r_widx[1:0] == 2'd0);
        w_phase4    = r_k256 && (r_widx[2:0] == 3'd4);
        w_last_word = r_k256 ? 6'd59 : 6'd43;
        if (w_phase0)      w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
        else if (w_phase4) w_temp = sub_word(w_prev);
        else               w_temp = w_prev;
    end

    always_ff @(posedge clk) begin
        if (init) begin
            for (int unsigned i = 0; i < 8; i++) r_w[i] <= key[255-32*i -: 32];
        end else if (r_state == C_KEYEXP) begin
            r_w[r_widx] <= w_back ^ w_temp;
        end
    end

    // init restarts the key schedule from any state so an abandoned block never blocks rekeying.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= C_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_blk    <= '0;
            r_round  <= '0;
            r_nr     <= 4'd10;
            r_enc    <= 1'b0;
            r_k256   <= 1'b0;
            r_widx   <= '0;
            r_rcon   <= 8'h01;
        end else if (init) begin
            r_k256  <= keylen;
            r_nr    <= keylen ? 4'd14 : 4'd10;
            r_widx  <= keylen ? 6'd8 : 6'd4;
            r_rcon  <= 8'h01;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_state <= C_KEYEXP;
        end else begin
            case (r_state)
                C_IDLE: if (next) begin
                    r_enc   <= encdec;
                    r_blk   <= block ^ w_rk;
                    r_round <= 4'd1;
                    r_ready <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= C_RUN;
                end
                C_KEYEXP: begin
                    if (w_phase0) r_rcon <= xtime(r_rcon);
                    if (r_widx == w_last_word) begin
                        r_ready <= 1'b1;
                        r_state <= C_IDLE;
                    end else begin
                        r_widx <= r_widx + 6'd1;
                    end
                end
                C_RUN: begin
                    if (r_round == r_nr) begin
                        r_result <= r_enc ? enc_round(r_blk, w_rk, 1'b1) : dec_round(r_blk, w_rk, 1'b1);
                        r_ready  <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= C_IDLE;
                    end else begin
                        r_blk   <= r_enc ? enc_round(r_blk, w_rk, 1'b0) : dec_round(r_blk, w_rk, 1'b0);
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign ready        = r_ready;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule

// File: rtl/aes_cbc_engine.sv
// Multi-block AES-CBC encrypt/decrypt engine around aes_core.
// Optional ECB bypass (port ecb) when AES_CBC_ECB_MODE_EN is defined.
module aes_cbc_engine
    import aes_cbc_pkg::*;
#(
    parameter int unsigned      LEN_W    = 16,
    parameter logic [BLK_W-1:0] IV_RESET = 128'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             encdec,
    input  logic             keylen,
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] iv,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             start,
    input  logic             abort,
`ifdef AES_CBC_ECB_MODE_EN
    input  logic             ecb,
`endif
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    cbc_state_t       r_state;
    cbc_state_t       w_next;
    logic             r_encdec;
    logic             r_keylen;
    logic [KEY_W-1:0] r_key;
    logic [LEN_W-1:0] r_msg_len;
    logic [LEN_W-1:0] r_count;
    logic [BLK_W-1:0] r_blk_in;
    logic [BLK_W-1:0] r_core_block;
    logic [BLK_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_skip;

    logic             w_start_ok;
    logic             w_in_take;
    logic             w_result_take;
    logic             w_out_take;
    logic             w_bypass;
    logic             w_encrypt;
    logic [BLK_W-1:0] w_core_block;
    logic [BLK_W-1:0] w_chain_out;
    logic             w_core_ready;
    logic             w_core_valid;
    logic [BLK_W-1:0] w_core_result;
    logic             w_core_reset_n;
    logic [LEN_W-1:0] w_last_idx;

`ifdef AES_CBC_ECB_MODE_EN
    logic r_ecb;
    assign w_bypass = r_ecb;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_encrypt      = (r_encdec == ENC);
    assign w_core_reset_n = ~reset;
    assign w_last_idx     = r_msg_len - LEN_W'(1);

    always_comb begin
        w_next        = r_state;
        w_start_ok    = 1'b0;
        w_in_take     = 1'b0;
        w_result_take = 1'b0;
        w_out_take    = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_start_ok = 1'b1;
                w_next     = (msg_len == '0) ? S_FIN : S_KEYINIT;
            end
            S_KEYINIT:   w_next = S_KEYWAIT;
            S_KEYWAIT:   if (!r_skip && w_core_ready) w_next = S_WAIT_IN;
            S_WAIT_IN:   if (in_valid) begin
                w_in_take = 1'b1;
                w_next    = S_CORE_GO;
            end
            S_CORE_GO:   w_next = S_CORE_WAIT;
            S_CORE_WAIT: if (!r_skip && w_core_ready && w_core_valid) begin
                w_result_take = 1'b1;
                w_next        = S_OUT;
            end
            S_OUT:       if (out_ready) begin
                w_out_take = 1'b1;
                w_next     = (r_count == w_last_idx) ? S_FIN : S_WAIT_IN;
            end
            S_FIN:       w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next        = S_IDLE;
            w_start_ok    = 1'b0;
            w_in_take     = 1'b0;
            w_result_take = 1'b0;
            w_out_take    = 1'b0;
        end
    end

    // r_skip masks the core's stale ready/result_valid in the first wait cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_encdec     <= ENC;
            r_keylen     <= KEYLEN_128;
            r_key        <= '0;
            r_msg_len    <= '0;
            r_count      <= '0;
            r_blk_in     <= '0;
            r_core_block <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skip       <= 1'b0;
`ifdef AES_CBC_ECB_MODE_EN
            r_ecb        <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_skip  <= (r_state == S_KEYINIT) || (r_state == S_CORE_GO);
            if (w_start_ok) begin
                r_encdec  <= encdec;
                r_keylen  <= keylen;
                r_key     <= key;
                r_msg_len <= msg_len;
                r_count   <= '0;
`ifdef AES_CBC_ECB_MODE_EN
                r_ecb     <= ecb;
`endif
            end
            if (w_in_take) begin
                r_blk_in     <= in_data;
                r_core_block <= w_core_block;
            end
            if (w_result_take) begin
                r_out_data  <= w_chain_out;
                r_out_valid <= 1'b1;
            end
            if (w_out_take) begin
                r_out_valid <= 1'b0;
                r_count     <= r_count + LEN_W'(1);
            end
            if (abort) begin
                r_out_valid <= 1'b0;
                r_count     <= '0;
            end
        end
    end

    aes_cbc_chain #(
        .IV_RESET (IV_RESET)
    ) u_chain (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_start_ok),
        .i_update     (w_result_take),
        .i_encrypt    (w_encrypt),
        .i_bypass     (w_bypass),
        .i_iv         (iv),
        .i_in_data    (in_data),
        .i_blk_in     (r_blk_in),
        .i_result     (w_core_result),
        .o_core_block (w_core_block),
        .o_out_data   (w_chain_out)
    );

    aes_core u_core (
        .clk          (clk),
        .reset_n      (w_core_reset_n),
        .encdec       (r_encdec),
        .init         (r_state == S_KEYINIT),
        .next         (r_state == S_CORE_GO),
        .ready        (w_core_ready),
        .key          (r_key),
        .keylen       (r_keylen),
        .block        (r_core_block),
        .result       (w_core_result),
        .result_valid (w_core_valid)
    );

    assign in_ready  = (r_state == S_WAIT_IN) && !abort;
    assign done      = (r_state == S_FIN) && !abort;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_cbc_engine.sv
// Directed bench for aes_cbc_engine: CBC model built on known AES block pairs.
module tb_aes_cbc_engine;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] IV0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2   = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] C256 = 128'hf58c4c04d6e5f1ba779eabfb5f7bfbd6;
    localparam logic [127:0] E1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic         clk = 1'b0;
    logic         reset, encdec, keylen, start, abort, in_valid, out_ready;
    logic [255:0] key;
    logic [127:0] iv, in_data, out_data;
    logic [15:0]  msg_len;
    logic         in_ready, out_valid, busy, done;
`ifdef AES_CBC_ECB_MODE_EN
    logic         ecb;
`endif

    aes_cbc_engine #(
        .LEN_W    (16),
        .IV_RESET (128'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .encdec    (encdec),
        .keylen    (keylen),
        .key       (key),
        .iv        (iv),
        .msg_len   (msg_len),
        .start     (start),
        .abort     (abort),
`ifdef AES_CBC_ECB_MODE_EN
        .ecb       (ecb),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    int unsigned  done_cnt = 0;
    logic [255:0] t_key [4];
    logic [127:0] t_x [4];
    logic [127:0] t_y [4];
    logic [127:0] tb_blk [4];
    logic [127:0] got [$];
    logic [127:0] exp_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Known AES block pairs; the CBC model below combines them.
    function automatic logic fwd(input logic [255:0] k, input logic [127:0] x, output logic [127:0] y);
        y = '0;
        for (int i = 0; i < 4; i++)
            if (t_key[i] == k && t_x[i] == x) begin
                y = t_y[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic logic inv(input logic [255:0] k, input logic [127:0] y, output logic [127:0] x);
        x = '0;
        for (int i = 0; i < 4; i++)
            if (t_key[i] == k && t_y[i] == y) begin
                x = t_x[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    logic         m_enc, m_ecb, p_hold;
    logic [255:0] m_key;
    logic [127:0] m_chain, p_data;

    always @(negedge clk) begin
        logic [127:0] x;
        logic [127:0] y;
        if (reset) begin
            exp_q.delete();
            p_hold = 1'b0;
        end else begin
            if (p_hold && out_valid) chk("hold_data", out_data, p_data);
            if (abort) begin
                exp_q.delete();
            end else begin
                if (start && !busy) begin
                    m_enc   = encdec;
                    m_key   = keylen ? key : {key[255:128], 128'h0};
                    m_chain = iv;
`ifdef AES_CBC_ECB_MODE_EN
                    m_ecb   = ecb;
`else
                    m_ecb   = 1'b0;
`endif
                    exp_q.delete();
                end
                if (in_valid && in_ready) begin
                    if (m_enc) begin
                        x = m_ecb ? in_data : (m_chain ^ in_data);
                        if (!fwd(m_key, x, y)) fail("model_fwd_lookup");
                        exp_q.push_back(y);
                        if (!m_ecb) m_chain = y;
                    end else begin
                        if (!inv(m_key, in_data, y)) fail("model_inv_lookup");
                        exp_q.push_back(m_ecb ? y : (y ^ m_chain));
                        if (!m_ecb) m_chain = in_data;
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail("unexpected_out");
                    else chk("out_data", out_data, exp_q.pop_front());
                end
                if (done) done_cnt++;
            end
            p_hold = out_valid && !out_ready;
            p_data = out_data;
        end
    end

    task automatic chk_got(input string name, input int unsigned idx, input logic [127:0] exp);
        if (idx >= got.size()) fail(name);
        else chk(name, got[idx], exp);
    endtask

    task automatic run_msg(input logic enc, input logic kl, input logic [255:0] k,
                           input logic [127:0] v, input logic [15:0] len, input int unsigned hold);
        int unsigned t;
        got.delete();
        encdec = enc; keylen = kl; key = k; iv = v; msg_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned b = 0; b < len; b++) begin
            t = 0;
            while (!in_ready && t < 400) begin tick(); t++; end
            if (!in_ready) begin fail("in_ready_timeout"); return; end
            in_data = tb_blk[b]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            t = 0;
            while (!out_valid && t < 400) begin tick(); t++; end
            if (!out_valid) begin fail("out_valid_timeout"); return; end
            if (b == 0) begin
                for (int unsigned i = 0; i < hold; i++) begin
                    chk("bp_in_ready", {127'h0, in_ready}, 128'h0);
                    chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
                    if (i == 5) begin start = 1'b1; iv = '1; end
                    if (i == 6) start = 1'b0;
                    tick();
                end
                start = 1'b0;
            end
            out_ready = 1'b1;
            got.push_back(out_data);
            tick();
            out_ready = 1'b0;
        end
        t = 0;
        while (busy && t < 50) begin tick(); t++; end
        if (busy) fail("busy_timeout");
    endtask

    initial begin
        int unsigned d0;
        logic        saw;
        t_key[0] = K128; t_x[0] = P1 ^ IV0; t_y[0] = C1;
        t_key[1] = K128; t_x[1] = P2 ^ C1;  t_y[1] = C2;
        t_key[2] = K256; t_x[2] = P1 ^ IV0; t_y[2] = C256;
        t_key[3] = K128; t_x[3] = P1;       t_y[3] = E1;
        reset = 1'b1; encdec = 1'b1; keylen = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; key = '0; iv = '0; in_data = '0; msg_len = '0;
`ifdef AES_CBC_ECB_MODE_EN
        ecb = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_in_ready", {127'h0, in_ready}, 128'h0);
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        chk("rst_done", {127'h0, done}, 128'h0);
        reset = 1'b0;
        tick();

        tb_blk[0] = P1; tb_blk[1] = P2;
        d0 = done_cnt;
        run_msg(1'b1, 1'b0, K128, IV0, 16'd2, 0);
        chk_got("enc128_c1", 0, C1);
        chk_got("enc128_c2", 1, C2);
        chk("enc128_done", 128'(done_cnt - d0), 128'd1);

        tb_blk[0] = C1; tb_blk[1] = C2;
        d0 = done_cnt;
        run_msg(1'b0, 1'b0, K128, IV0, 16'd2, 0);
        chk_got("dec128_p1", 0, P1);
        chk_got("dec128_p2", 1, P2);
        chk("dec128_done", 128'(done_cnt - d0), 128'd1);

        tb_blk[0] = P1;
        run_msg(1'b1, 1'b1, K256, IV0, 16'd1, 0);
        chk_got("enc256_c1", 0, C256);

        tb_blk[0] = P1; tb_blk[1] = P2;
        run_msg(1'b1, 1'b0, K128, IV0, 16'd2, 20);
        chk_got("bp_c1", 0, C1);
        chk_got("bp_c2", 1, C2);

        d0 = done_cnt;
        msg_len = '0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done_hi", {127'h0, done}, 128'h1);
        chk("len0_out_valid", {127'h0, out_valid}, 128'h0);
        tick();
        chk("len0_done_lo", {127'h0, done}, 128'h0);
        chk("len0_idle", {127'h0, busy}, 128'h0);
        repeat (3) tick();
        chk("len0_done_cnt", 128'(done_cnt - d0), 128'd1);

        encdec = 1'b1; keylen = 1'b0; key = K128; iv = IV0; msg_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        d0 = 0;
        while (!in_ready && d0 < 400) begin tick(); d0++; end
        if (!in_ready) fail("abort_in_ready_timeout");
        in_data = P1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {127'h0, busy}, 128'h0);
        chk("abort_out_valid", {127'h0, out_valid}, 128'h0);
        d0 = done_cnt;
        saw = 1'b0;
        repeat (30) begin
            if (out_valid || in_ready) saw = 1'b1;
            tick();
        end
        chk("abort_quiet", {127'h0, saw}, 128'h0);
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
        tb_blk[0] = P1; tb_blk[1] = P2;
        run_msg(1'b1, 1'b0, K128, IV0, 16'd2, 0);
        chk_got("post_abort_c1", 0, C1);
        chk_got("post_abort_c2", 1, C2);

`ifdef AES_CBC_ECB_MODE_EN
        ecb = 1'b1;
        tb_blk[0] = P1;
        run_msg(1'b1, 1'b0, K128, IV0, 16'd1, 0);
        chk_got("ecb128", 0, E1);
        ecb = 1'b0;
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
